// File: rtl/inverter_bank_tester.sv
// Self-test sequencer for a 6-unit hex inverter bank: drives a fixed vector set,
// checks the inverted response and reports sticky per-unit faults. Optional macro: INV_TEST_CAPTURE_EN.
module inverter_bank_tester #(
  parameter int N_UNITS       = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic [N_UNITS-1:0] DRV,
  input  logic [N_UNITS-1:0] SNS,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic [N_UNITS-1:0] FAIL
`ifdef INV_TEST_CAPTURE_EN
  ,
  output logic [2:0]         FIRST_VEC,
  output logic               FAIL_SEEN
`endif
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

  state_t             state, state_n;
  logic [2:0]         v, v_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [N_UNITS-1:0] drv_n, fail_n, mismatch;
  logic               busy_n, done_n, pass_n;
`ifdef INV_TEST_CAPTURE_EN
  logic [2:0]         first_vec_n;
  logic               fail_seen_n;
`endif

  // Vector 0 is all-low, vector 1 all-high, vectors 2..7 walk a single one upward.
  function automatic logic [N_UNITS-1:0] vec(input logic [2:0] idx);
    case (idx)
      3'd0:    vec = '0;
      3'd1:    vec = '1;
      default: vec = {{(N_UNITS-1){1'b0}}, 1'b1} << (idx - 3'd2);
    endcase
  endfunction

  assign mismatch = SNS ^ ~DRV;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave one unassigned (no latch).
    state_n = state;
    v_n     = v;
    cnt_n   = cnt;
    drv_n   = DRV;
    fail_n  = FAIL;
    pass_n  = PASS;
    busy_n  = BUSY;
    done_n  = 1'b0;
`ifdef INV_TEST_CAPTURE_EN
    first_vec_n = FIRST_VEC;
    fail_seen_n = FAIL_SEEN;
`endif
    case (state)
      IDLE: begin
        drv_n = '0;
        if (START) begin
          v_n     = 3'd0;
          drv_n   = vec(3'd0);
          fail_n  = '0;
          pass_n  = 1'b0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = SETTLE;
`ifdef INV_TEST_CAPTURE_EN
          first_vec_n = 3'd0;
          fail_seen_n = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (cnt == CNT_LAST) state_n = SAMPLE;
        else                 cnt_n   = cnt + 1'b1;
      end
      SAMPLE: begin
        fail_n = FAIL | mismatch;
`ifdef INV_TEST_CAPTURE_EN
        if (!FAIL_SEEN && (|mismatch)) begin
          first_vec_n = v;
          fail_seen_n = 1'b1;
        end
`endif
        if (v == 3'd7) begin
          // PASS must already reflect this last sample during the DONE cycle.
          pass_n  = ~|(FAIL | mismatch);
          done_n  = 1'b1;
          state_n = FINISH;
        end else begin
          v_n     = v + 3'd1;
          drv_n   = vec(v + 3'd1);
          cnt_n   = '0;
          state_n = SETTLE;
        end
      end
      FINISH: begin
        drv_n   = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      v     <= '0;
      cnt   <= '0;
      DRV   <= '0;
      FAIL  <= '0;
      PASS  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
`ifdef INV_TEST_CAPTURE_EN
      FIRST_VEC <= '0;
      FAIL_SEEN <= 1'b0;
`endif
    end else begin
      state <= state_n;
      v     <= v_n;
      cnt   <= cnt_n;
      DRV   <= drv_n;
      FAIL  <= fail_n;
      PASS  <= pass_n;
      BUSY  <= busy_n;
      DONE  <= done_n;
`ifdef INV_TEST_CAPTURE_EN
      FIRST_VEC <= first_vec_n;
      FAIL_SEEN <= fail_seen_n;
`endif
    end
  end

endmodule

// File: tb/tb_inverter_bank_tester.sv
// Self-checking bench for inverter_bank_tester: fault-table vectors, multi-cycle corner
// sequences and randomized fault models checked against a run-level reference model.
module tb_inverter_bank_tester;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start_a, start_b;
  logic [5:0] drv_a, sns_a, fail_a, drv_b, sns_b, fail_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
`ifdef INV_TEST_CAPTURE_EN
  logic [2:0] first_a, first_b;
  logic       seen_a, seen_b;
`endif

  // Bank "a" fault model knobs
  logic [5:0] sa0, sa1;
  bit         short23;
  int         delay_a;
  logic [5:0] pipe_a [0:3];
  logic [5:0] pipe_b [0:3];

  int ntests = 0;
  int nfail  = 0;

  always #5 CLK = ~CLK;

  inverter_bank_tester #(.N_UNITS(6), .SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .START(start_a), .DRV(drv_a), .SNS(sns_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .FAIL(fail_a)
`ifdef INV_TEST_CAPTURE_EN
    , .FIRST_VEC(first_a), .FAIL_SEEN(seen_a)
`endif
  );

  inverter_bank_tester #(.N_UNITS(6), .SETTLE_CYCLES(4)) dut4 (
    .CLK(CLK), .RST(RST), .START(start_b), .DRV(drv_b), .SNS(sns_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .FAIL(fail_b)
`ifdef INV_TEST_CAPTURE_EN
    , .FIRST_VEC(first_b), .FAIL_SEEN(seen_b)
`endif
  );

  // Inverter banks with registered propagation delay
  always @(posedge CLK) begin
    pipe_a[0] <= ~drv_a;
    pipe_b[0] <= ~drv_b;
    for (int i = 1; i < 4; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end

  always_comb begin
    logic [5:0] y;
    y = pipe_a[delay_a-1];
    y = (y & ~sa0) | sa1;
    if (short23) begin
      y[1] = y[1] & y[2];
      y[2] = y[1];
    end
    sns_a = y;
    sns_b = pipe_b[2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] vec_of(input int v);
    if (v == 0) return 6'h00;
    if (v == 1) return 6'h3F;
    return 6'(1 << (v - 2));
  endfunction

  // Run-level model: the bank returns the inverse of whatever was driven `d` edges before the
  // sample, so a bank slower than the settle window reports the previous vector's response.
  task automatic model(input logic [5:0] s0, input logic [5:0] s1, input bit sh, input int d,
                       input int settle, output logic [5:0] f, output logic [2:0] first,
                       output bit seen);
    logic [5:0] applied, y, m;
    f = '0; first = '0; seen = 0;
    for (int v = 0; v < 8; v++) begin
      applied = (d <= settle) ? vec_of(v) : ((v == 0) ? 6'h00 : vec_of(v - 1));
      y = (~applied & ~s0) | s1;
      if (sh) begin
        y[1] = y[1] & y[2];
        y[2] = y[1];
      end
      m = y ^ ~vec_of(v);
      if (m != 0 && !seen) begin
        seen  = 1;
        first = 3'(v);
      end
      f |= m;
    end
  endtask

  // One full run: START pulse, watch for DONE within a bounded budget, check post-DONE state.
  task automatic run(input bit use_b, input bit drv_chk, input int exp_edges, input string tag,
                     output logic [5:0] f, output bit p, output logic [2:0] fv, output bit fs);
    int n;
    @(negedge CLK);
    if (use_b) start_b = 1; else start_a = 1;
    @(posedge CLK); #1;
    start_a = 0; start_b = 0;
    n = 0;
    check({tag, "_busy_at_start"}, use_b ? busy_b : busy_a, 1);
    check({tag, "_pass_cleared"}, use_b ? pass_b : pass_a, 0);
    check({tag, "_fail_cleared"}, use_b ? fail_b : fail_a, 0);
    while (!(use_b ? done_b : done_a) && n < exp_edges + 20) begin
      if (drv_chk) begin
        check($sformatf("%s_drv%0d", tag, n), drv_a, vec_of(n / 3));
        check($sformatf("%s_busy%0d", tag, n), busy_a, 1);
      end
      @(posedge CLK); #1;
      n++;
    end
    check({tag, "_done_edge"}, n, exp_edges);
    f  = use_b ? fail_b : fail_a;
    p  = use_b ? pass_b : pass_a;
    fv = '0;
    fs = 0;
`ifdef INV_TEST_CAPTURE_EN
    fv = use_b ? first_b : first_a;
    fs = use_b ? seen_b : seen_a;
`endif
    check({tag, "_busy_in_done"}, use_b ? busy_b : busy_a, 1);
    @(posedge CLK); #1;
    check({tag, "_done_one_cycle"}, use_b ? done_b : done_a, 0);
    check({tag, "_busy_after"}, use_b ? busy_b : busy_a, 0);
    check({tag, "_drv_after"}, use_b ? drv_b : drv_a, 0);
    check({tag, "_pass_held"}, use_b ? pass_b : pass_a, 32'(p));
  endtask

  typedef struct {
    string      name;
    logic [5:0] sa0;
    logic [5:0] sa1;
    bit         short23;
    int         delay;
    logic [5:0] exp_fail;
    bit         exp_pass;
    logic [2:0] exp_first;
  } vec_t;

  initial begin
    vec_t       tbl [5];
    logic [5:0] f, mf;
    logic [2:0] fv, mfv;
    bit         p, fs, mfs, saw_done;
    int         n;

    tbl[0] = '{"good",      6'h00, 6'h00, 0, 1, 6'h00, 1, 3'd0};
    tbl[1] = '{"y4_sa0",    6'h08, 6'h00, 0, 1, 6'h08, 0, 3'd0};
    tbl[2] = '{"y2y3_short",6'h00, 6'h00, 1, 1, 6'h06, 0, 3'd3};
    tbl[3] = '{"y1_sa1",    6'h00, 6'h01, 0, 1, 6'h01, 0, 3'd1};
    tbl[4] = '{"slow_s2",   6'h00, 6'h00, 0, 3, 6'h3F, 0, 3'd1};

    start_a = 0; start_b = 0; sa0 = 0; sa1 = 0; short23 = 0; delay_a = 1;
    RST = 1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_drv", drv_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_fail", fail_a, 0);
    @(negedge CLK);
    RST = 0;

    // Table of fault models on the SETTLE_CYCLES=2 instance
    for (int i = 0; i < 5; i++) begin
      sa0 = tbl[i].sa0; sa1 = tbl[i].sa1; short23 = tbl[i].short23; delay_a = tbl[i].delay;
      run(0, i == 0, 24, tbl[i].name, f, p, fv, fs);
      check({tbl[i].name, "_fail"}, f, tbl[i].exp_fail);
      check({tbl[i].name, "_pass"}, p, tbl[i].exp_pass);
`ifdef INV_TEST_CAPTURE_EN
      check({tbl[i].name, "_first_vec"}, fv, tbl[i].exp_first);
      check({tbl[i].name, "_fail_seen"}, fs, tbl[i].exp_fail != 0);
`endif
    end

    // Slow bank on the SETTLE_CYCLES=4 instance
    run(1, 0, 40, "slow_s4", f, p, fv, fs);
    check("slow_s4_fail", f, 0);
    check("slow_s4_pass", p, 1);

    // START pulsed mid-run, then held high across DONE
    sa0 = 6'h08; short23 = 0; sa1 = 0; delay_a = 1;
    @(negedge CLK); start_a = 1;
    @(posedge CLK); #1; start_a = 0;
    n = 0;
    while (!done_a && n < 44) begin
      start_a = (n == 5 || n == 14 || n >= 20);
      @(posedge CLK); #1;
      n++;
    end
    check("restart_done_edge", n, 24);
    check("restart_fail1", fail_a, 6'h08);
    @(posedge CLK); #1;
    check("restart_idle_busy", busy_a, 0);
    @(posedge CLK); #1;
    start_a = 0; sa0 = 0;
    check("restart_busy2", busy_a, 1);
    check("restart_fail_cleared", fail_a, 0);
    check("restart_pass_cleared", pass_a, 0);
    n = 0;
    while (!done_a && n < 44) begin
      @(posedge CLK); #1;
      n++;
    end
    check("restart2_done_edge", n, 24);
    check("restart2_pass", pass_a, 1);
    @(posedge CLK); #1;

    // Asynchronous reset during SETTLE of vector 4
    sa0 = 6'h08;
    @(negedge CLK); start_a = 1;
    @(posedge CLK); #1; start_a = 0;
    repeat (13) @(posedge CLK);
    #2;
    check("abort_drv_before", drv_a, 6'h04);
    check("abort_fail_before", fail_a, 6'h08);
    RST = 1;
    #1;
    check("abort_drv", drv_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_fail", fail_a, 0);
    @(negedge CLK);
    RST = 0; sa0 = 0;
    saw_done = 0;
    repeat (30) begin
      @(posedge CLK); #1;
      saw_done |= done_a;
    end
    check("abort_no_done", saw_done, 0);
    run(0, 0, 24, "after_abort", f, p, fv, fs);
    check("after_abort_pass", p, 1);

    // Randomized fault models against the reference model
    for (int i = 0; i < 20; i++) begin
      sa0     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
      sa1     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
      short23 = ($urandom_range(0, 3) == 0);
      delay_a = $urandom_range(1, 3);
      model(sa0, sa1, short23, delay_a, 2, mf, mfv, mfs);
      run(0, 0, 24, $sformatf("rnd%0d", i), f, p, fv, fs);
      check($sformatf("rnd%0d_fail", i), f, mf);
      check($sformatf("rnd%0d_pass", i), p, mf == 0);
`ifdef INV_TEST_CAPTURE_EN
      check($sformatf("rnd%0d_first_vec", i), fv, mfv);
      check($sformatf("rnd%0d_fail_seen", i), fs, mfs);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
